// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter: a CPU write to TRIG_ADDR copies one 256-byte page to DEST_ADDR.
// The CPU is stalled through its ready input for the whole transfer.
module dma_bus_arbiter #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter bit          ALIGN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  input  logic        ext_ready,
  input  logic [7:0]  mem_data_i,
  output logic        cpu_ready,
  output logic [15:0] mem_address,
  output logic        mem_write,
  output logic [7:0]  mem_data_o,
  output logic        dma_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PEND   = 3'd1,
    HALT   = 3'd2,
    ALIGNC = 3'd3,
    RD     = 3'd4,
    WR     = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  buf_q;
  logic        parity;
  logic        trig;

  assign trig = cpu_write && (cpu_address == TRIG_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      page     <= '0;
      idx      <= '0;
      buf_q    <= '0;
      parity   <= 1'b0;
      dma_busy <= 1'b0;
    end else begin
      state    <= state_nx;
      parity   <= ~parity;
      dma_busy <= (state_nx != IDLE);
      if (state == IDLE && trig) begin
        page <= cpu_data_o;
        idx  <= '0;
      end
      if (state == RD && ext_ready) buf_q <= mem_data_i;
      // 8-bit wrap returns idx to 0 after the last byte of the page
      if (state == WR) idx <= idx + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (trig) state_nx = PEND;
      PEND:    if (!cpu_write) state_nx = HALT;
      HALT:    state_nx = (!ALIGN || parity) ? RD : ALIGNC;
      ALIGNC:  state_nx = RD;
      RD:      if (ext_ready) state_nx = WR;
      WR:      state_nx = (idx == 8'hFF) ? IDLE : RD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_address = cpu_address;
    mem_write   = cpu_write;
    mem_data_o  = cpu_data_o;
    cpu_ready   = 1'b0;
    unique case (state)
      IDLE:    cpu_ready = ext_ready;
      ALIGNC:  mem_write = 1'b0;
      RD: begin
        mem_address = {page, idx};
        mem_write   = 1'b0;
        mem_data_o  = buf_q;
      end
      WR: begin
        mem_address = DEST_ADDR;
        mem_write   = 1'b1;
        mem_data_o  = buf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: pass-through vector table plus scoreboarded page copies.
// A second instance with ALIGN=0 shares the stimulus to check the unaligned stall count.
module tb_dma_bus_arbiter;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
  localparam logic [15:0] CPU_RD = 16'h8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_write;
  logic [7:0]  cpu_data_o;
  logic        ext_ready;
  logic [7:0]  mem_data_i, mem_data_i_na;
  logic        cpu_ready, cpu_ready_na;
  logic [15:0] mem_address, mem_address_na;
  logic        mem_write, mem_write_na;
  logic [7:0]  mem_data_o, mem_data_o_na;
  logic        dma_busy, dma_busy_na;

  logic [7:0]  mem [0:65535];
  assign mem_data_i    = mem[mem_address];
  assign mem_data_i_na = mem[mem_address_na];

  always #5 clk = ~clk;

  dma_bus_arbiter #(.TRIG_ADDR(TRIG), .DEST_ADDR(DEST), .ALIGN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_data_o(cpu_data_o), .ext_ready(ext_ready), .mem_data_i(mem_data_i),
    .cpu_ready(cpu_ready), .mem_address(mem_address), .mem_write(mem_write),
    .mem_data_o(mem_data_o), .dma_busy(dma_busy));

  dma_bus_arbiter #(.TRIG_ADDR(TRIG), .DEST_ADDR(DEST), .ALIGN(1'b0)) u_dut_na (
    .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_data_o(cpu_data_o), .ext_ready(ext_ready), .mem_data_i(mem_data_i_na),
    .cpu_ready(cpu_ready_na), .mem_address(mem_address_na), .mem_write(mem_write_na),
    .mem_data_o(mem_data_o_na), .dma_busy(dma_busy_na));

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rdy;
    logic [15:0] x_addr;
    logic        x_wr;
    logic [7:0]  x_data;
    logic        x_rdy;
    logic        x_busy;
  } vec_t;

  vec_t        vt [6];
  logic [23:0] exp_q [$];
  int          n_pass = 0;
  int          n_total = 0;
  int          stall = 0;
  int          stall_na = 0;
  logic        par_model = 1'b0;
  logic [15:0] pa [2];
  logic [7:0]  pd [2];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic void push(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endfunction

  function automatic void observe();
    logic [23:0] e;
    if (mem_write) begin
      if (exp_q.size() == 0) chk("unexpected_write", {8'h0, mem_address, mem_data_o}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", {16'h0, mem_address}, {16'h0, e[23:8]});
        chk("wr_data", {24'h0, mem_data_o}, {24'h0, e[7:0]});
      end
    end
    if (!cpu_ready) stall++;
    if (!cpu_ready_na) stall_na++;
  endfunction

  task automatic step(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic rdy, input logic rst);
    @(negedge clk);
    cpu_write = w; cpu_address = a; cpu_data_o = d; ext_ready = rdy; reset = rst;
    #2;
    observe();
    par_model = rst ? ~par_model : 1'b0;
  endtask

  task automatic sync_parity(input logic p);
    while (par_model != p) step(1'b0, CPU_RD, 8'h00, 1'b1, 1'b1);
  endtask

  // al: whether an alignment cycle is expected after HALT
  task automatic run_copy(input logic [7:0] pg, input int n_pend, input int wait_idx,
                          input int abort_idx, input logic al, input string nm);
    int n, s, ws, ab;
    logic rdy, rst, done;
    logic [7:0] orig;
    push(TRIG, pg);
    step(1'b1, TRIG, pg, 1'b1, 1'b1);
    for (int i = 0; i < n_pend; i++) begin
      push(pa[i], pd[i]);
      step(1'b1, pa[i], pd[i], 1'b1, 1'b1);
      chk({nm, "_pend_busy"}, {31'h0, dma_busy}, 32'd1);
    end
    n = (abort_idx >= 0) ? abort_idx + 1 : 256;
    for (int i = 0; i < n; i++)
      push(DEST, (i == wait_idx) ? 8'h5A : mem[{pg, 8'(i)}]);
    step(1'b0, CPU_RD, 8'h00, 1'b1, 1'b1);
    chk({nm, "_pend_ready"}, {31'h0, cpu_ready}, 32'd0);
    ws   = (wait_idx >= 0) ? 2 + int'(al) + 2 * wait_idx : -10;
    ab   = (abort_idx >= 0) ? 3 + int'(al) + 2 * abort_idx : -10;
    orig = (wait_idx >= 0) ? mem[{pg, 8'(wait_idx)}] : 8'h00;
    stall = 0; stall_na = 0; s = 0; done = 1'b0;
    while (!done && s < 1200) begin
      s++;
      rdy = 1'b1; rst = 1'b1;
      if (s >= ws && s < ws + 3) begin
        rdy = 1'b0;
        mem[{pg, 8'(wait_idx)}] = 8'hE0 + 8'(s - ws);
      end
      if (s == ws + 3) mem[{pg, 8'(wait_idx)}] = 8'h5A;
      if (s == ab) rst = 1'b0;
      step(1'b0, CPU_RD, 8'h00, rdy, rst);
      if (s >= ws && s <= ws + 3) begin
        chk({nm, "_wait_addr"}, {16'h0, mem_address}, {16'h0, pg, 8'(wait_idx)});
        chk({nm, "_wait_wr"}, {31'h0, mem_write}, 32'd0);
      end
      if (!rst) begin
        chk({nm, "_abort_wr"}, {31'h0, mem_write}, 32'd1);
        done = 1'b1;
      end else if (cpu_ready) done = 1'b1;
    end
    chk({nm, "_finished"}, {31'h0, done}, 32'd1);
    if (wait_idx >= 0) mem[{pg, 8'(wait_idx)}] = orig;
    if (abort_idx < 0) begin
      chk({nm, "_stall"}, stall, 513 + int'(al) + ((wait_idx >= 0) ? 3 : 0));
      chk({nm, "_busy_end"}, {31'h0, dma_busy}, 32'd0);
      if (wait_idx < 0) chk({nm, "_stall_na"}, stall_na, 513);
    end
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[{8'h02, 8'(i)}] = 8'(i);
      mem[{8'h03, 8'(i)}] = 8'(i) ^ 8'hA5;
      mem[{8'h05, 8'(i)}] = 8'(i) ^ 8'hC0;
    end
    vt[0] = '{1'b0, 16'h4014, 8'h02, 1'b1, 16'h4014, 1'b0, 8'h02, 1'b1, 1'b0};
    vt[1] = '{1'b1, 16'h4015, 8'h02, 1'b1, 16'h4015, 1'b1, 8'h02, 1'b1, 1'b0};
    vt[2] = '{1'b1, 16'h4013, 8'h33, 1'b0, 16'h4013, 1'b1, 8'h33, 1'b0, 1'b0};
    vt[3] = '{1'b0, 16'h1234, 8'hAB, 1'b0, 16'h1234, 1'b0, 8'hAB, 1'b0, 1'b0};
    vt[4] = '{1'b1, 16'h2004, 8'h5C, 1'b1, 16'h2004, 1'b1, 8'h5C, 1'b1, 1'b0};
    vt[5] = '{1'b0, 16'hFFFF, 8'h00, 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b1, 1'b0};

    step(1'b0, CPU_RD, 8'h00, 1'b1, 1'b0);
    step(1'b0, CPU_RD, 8'h00, 1'b1, 1'b0);
    step(1'b0, 16'h0ABC, 8'h11, 1'b1, 1'b1);
    chk("rst_busy", {31'h0, dma_busy}, 32'd0);
    chk("rst_ready", {31'h0, cpu_ready}, 32'd1);
    chk("rst_addr", {16'h0, mem_address}, 32'h0ABC);
    chk("rst_wr", {31'h0, mem_write}, 32'd0);

    foreach (vt[i]) begin
      if (vt[i].w) push(vt[i].a, vt[i].d);
      step(vt[i].w, vt[i].a, vt[i].d, vt[i].rdy, 1'b1);
      chk("vec_addr", {16'h0, mem_address}, {16'h0, vt[i].x_addr});
      chk("vec_wr", {31'h0, mem_write}, {31'h0, vt[i].x_wr});
      chk("vec_data", {24'h0, mem_data_o}, {24'h0, vt[i].x_data});
      chk("vec_ready", {31'h0, cpu_ready}, {31'h0, vt[i].x_rdy});
      chk("vec_busy", {31'h0, dma_busy}, {31'h0, vt[i].x_busy});
    end

    sync_parity(1'b0);
    run_copy(8'h02, 0, -1, -1, 1'b1, "basic_align");
    sync_parity(1'b1);
    run_copy(8'h02, 0, -1, -1, 1'b0, "basic_noalign");

    pa[0] = 16'h0100; pd[0] = 8'h11;
    pa[1] = 16'h01FF; pd[1] = 8'h22;
    sync_parity(1'b0);
    run_copy(8'h02, 2, -1, -1, 1'b1, "pend_hold");

    pa[0] = TRIG; pd[0] = 8'h05;
    sync_parity(1'b1);
    run_copy(8'h03, 1, -1, -1, 1'b1, "retrigger");

    sync_parity(1'b0);
    run_copy(8'h02, 0, 16, -1, 1'b1, "wait_state");

    sync_parity(1'b0);
    run_copy(8'h02, 0, -1, 128, 1'b1, "abort");
    push(16'h0456, 8'h77);
    step(1'b1, 16'h0456, 8'h77, 1'b1, 1'b1);
    chk("abort_idle_busy", {31'h0, dma_busy}, 32'd0);
    chk("abort_idle_ready", {31'h0, cpu_ready}, 32'd1);
    chk("abort_idle_addr", {16'h0, mem_address}, 32'h0456);
    step(1'b0, CPU_RD, 8'h00, 1'b0, 1'b1);
    chk("abort_idle_ready_lo", {31'h0, cpu_ready}, 32'd0);
    chk("abort_idle_busy2", {31'h0, dma_busy}, 32'd0);
    sync_parity(1'b1);
    run_copy(8'h03, 0, -1, -1, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
